// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion compositor.
//   IDX_W          palette index width of a bitmap texel
//   palette_t      packed RGB triple, [2]=red [1]=green [0]=blue
//   PALETTE        fixed 4-entry colour table, entry 0 is transparent
//   motion_state_e once-per-frame motion controller states
//   axis_step      one bounce-motion step for a single axis
package sprite_pkg;

  localparam int IDX_W = 2;

  typedef logic [2:0][7:0] palette_t;

  localparam palette_t PALETTE [4] = '{
    24'h00_00_00,
    24'h20_20_20,
    24'hFF_00_00,
    24'hFF_FF_00
  };

  typedef enum logic {
    MS_IDLE   = 1'b0,
    MS_UPDATE = 1'b1
  } motion_state_e;

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;     // 1: moving towards larger coordinates
    logic        bounce;
  } axis_t;

  // span is the on-screen sprite size along this axis, screen the visible extent.
  function automatic axis_t axis_step(logic [15:0] pos, logic dir, int unsigned step,
                                      int unsigned span, int unsigned screen);
    axis_t      r;
    logic [16:0] nx;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    nx       = {1'b0, pos} + 17'(step);
    if (dir) begin
      if (32'(nx) + span > screen) begin
        r.pos    = 16'(screen - span);
        r.dir    = 1'b0;
        r.bounce = 1'b1;
      end else begin
        r.pos = nx[15:0];
      end
    end else if (32'(pos) < step) begin
      r.pos    = '0;
      r.dir    = 1'b1;
      r.bounce = 1'b1;
    end else begin
      r.pos = pos - 16'(step);
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_bitmap_ram.sv
// Sprite bitmap storage: one write port, one synchronous read port, single clock.
// A read of the address being written in the same cycle returns the previous contents.
// Contents are not reset.
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address, sampled every clock
//   o_rd_data  read data, valid one clock after i_rd_addr
module sprite_bitmap_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    rd_data_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/sprite_motion_compositor.sv
// Single-sprite renderer with autonomous bounce motion and a writable bitmap.
// Per pixel it emits palette RGB and an opaque-hit flag two clocks after (i_x,i_y).
// Position and flips advance once per frame on the rising edge of i_v_sync.
//   i_clk, i_rst               pixel clock, async active-high reset
//   i_x, i_y                   current pixel coordinate
//   i_v_sync                   vertical sync level
//   i_freeze                   hold motion; frame edges seen while frozen are dropped
//   i_wr_en/i_wr_addr/i_wr_data  bitmap write port, address = y*SPR_W + x
//   o_red, o_green, o_blue     pixel colour
//   o_sprite_hit               opaque sprite pixel
//   o_bounce                   one-cycle pulse when either axis bounced
//
// state     | meaning
// MS_IDLE   | waiting for a frame edge
// MS_UPDATE | apply one motion step to both axes this cycle
module sprite_motion_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W          = 32,
  parameter int unsigned SPR_H          = 8,
  parameter int unsigned SCALE_SH       = 3,
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned START_X        = 350,
  parameter int unsigned START_Y        = 16,
  parameter int unsigned STEP_X         = 1,
  parameter int unsigned STEP_Y         = 1,
  parameter bit          FLIP_ON_BOUNCE = 1'b1,
  parameter int          AW             = $clog2(SPR_W * SPR_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [15:0]   i_x,
  input  logic [15:0]   i_y,
  input  logic          i_v_sync,
  input  logic          i_freeze,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [1:0]    i_wr_data,
  output logic [7:0]    o_red,
  output logic [7:0]    o_green,
  output logic [7:0]    o_blue,
  output logic          o_sprite_hit,
  output logic          o_bounce
);

  localparam int          XW    = $clog2(SPR_W);
  localparam int          YW    = $clog2(SPR_H);
  localparam int unsigned W_PIX = SPR_W << SCALE_SH;
  localparam int unsigned H_PIX = SPR_H << SCALE_SH;

  motion_state_e state_q, state_d;
  logic [15:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  logic          v_sync_q, v_sync_d;
  logic          bounce_q, bounce_d;
  logic          hit_s1_q, hit_s1_d, hit_s2_q, hit_s2_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0] idx_s2;
  axis_t         ax, ay;
  logic [16:0]   px, py, x_end, y_end;
  logic [XW-1:0] rx, fx;
  logic [YW-1:0] ry, fy;
  palette_t      rgb;

  always_comb begin
    ax = axis_step(pos_x_q, dir_x_q, STEP_X, W_PIX, SCREEN_W);
    ay = axis_step(pos_y_q, dir_y_q, STEP_Y, H_PIX, SCREEN_H);

    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    flip_x_d = flip_x_q;
    flip_y_d = flip_y_q;
    v_sync_d = i_v_sync;
    bounce_d = 1'b0;

    case (state_q)
      MS_IDLE: if (!v_sync_q && i_v_sync && !i_freeze) state_d = MS_UPDATE;
      MS_UPDATE: begin
        state_d  = MS_IDLE;
        pos_x_d  = ax.pos;
        pos_y_d  = ay.pos;
        dir_x_d  = ax.dir;
        dir_y_d  = ay.dir;
        if (ax.bounce && FLIP_ON_BOUNCE) flip_x_d = ~flip_x_q;
        if (ay.bounce && FLIP_ON_BOUNCE) flip_y_d = ~flip_y_q;
        bounce_d = ax.bounce | ay.bounce;
      end
      default: state_d = MS_IDLE;
    endcase

    // Compares run at 17 bits so x+W past 65535 cannot wrap into a false hit.
    px       = {1'b0, i_x};
    py       = {1'b0, i_y};
    x_end    = {1'b0, pos_x_q} + 17'(W_PIX);
    y_end    = {1'b0, pos_y_q} + 17'(H_PIX);
    hit_s1_d = (px >= {1'b0, pos_x_q}) && (px < x_end) &&
               (py >= {1'b0, pos_y_q}) && (py < y_end);
    rx       = XW'((i_x - pos_x_q) >> SCALE_SH);
    ry       = YW'((i_y - pos_y_q) >> SCALE_SH);
    // Sizes are powers of two, so SIZE-1-r is a bitwise inversion.
    fx        = flip_x_q ? ~rx : rx;
    fy        = flip_y_q ? ~ry : ry;
    rd_addr_d = {fy, fx};
    hit_s2_d  = hit_s1_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= MS_IDLE;
      pos_x_q   <= 16'(START_X);
      pos_y_q   <= 16'(START_Y);
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      flip_x_q  <= 1'b0;
      flip_y_q  <= 1'b0;
      v_sync_q  <= 1'b1;
      bounce_q  <= 1'b0;
      hit_s1_q  <= 1'b0;
      hit_s2_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      flip_x_q  <= flip_x_d;
      flip_y_q  <= flip_y_d;
      v_sync_q  <= v_sync_d;
      bounce_q  <= bounce_d;
      hit_s1_q  <= hit_s1_d;
      hit_s2_q  <= hit_s2_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  sprite_bitmap_ram #(
    .DEPTH (SPR_W * SPR_H),
    .WIDTH (IDX_W),
    .AW    (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_addr_q),
    .o_rd_data (idx_s2)
  );

  // hit_s2_q is cleared by reset, which also blanks the unreset RAM output.
  assign rgb          = hit_s2_q ? PALETTE[idx_s2] : '0;
  assign o_red        = rgb[2];
  assign o_green      = rgb[1];
  assign o_blue       = rgb[0];
  assign o_sprite_hit = hit_s2_q && (idx_s2 != '0);
  assign o_bounce     = bounce_q;

endmodule

// File: tb/tb_sprite_motion_compositor.sv
module tb_sprite_motion_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ix, iy;
  logic        vsync, freeze, wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_data;
  logic [7:0]  red, green, blue;
  logic        hit, bounce;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_motion_compositor dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_x          (ix),
    .i_y          (iy),
    .i_v_sync     (vsync),
    .i_freeze     (freeze),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_red        (red),
    .o_green      (green),
    .o_blue       (blue),
    .o_sprite_hit (hit),
    .o_bounce     (bounce)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pal(input int idx);
    case (idx)
      1: return 32'h202020;
      2: return 32'hFF0000;
      3: return 32'hFFFF00;
      default: return 0;
    endcase
  endfunction

  // Behavioural model: sprite 256x64 pixels on a 640x480 screen.
  int  mx, my, mdx, mdy;
  bit  mfx, mfy, vs_prev, upd_pend, p_hit;
  int  p_addr;
  int  exp_rgb;
  bit  exp_hit, exp_bounce;
  bit [1:0] mem_m [256];

  function automatic void move(inout int p, inout int d, inout bit f, output bit b,
                               input int span, input int scr);
    b = 0;
    if (d == 1) begin
      if (p + 1 + span > scr) begin p = scr - span; d = 0; b = 1; end
      else p = p + 1;
    end else begin
      if (p < 1) begin p = 0; d = 1; b = 1; end
      else p = p - 1;
    end
    if (b) f = ~f;
  endfunction

  initial for (int a = 0; a < 256; a++) mem_m[a] = 0;

  always @(posedge clk) begin
    bit bx, by;
    int tx, ty, idx;
    if (rst) begin
      mx = 350; my = 16; mdx = 1; mdy = 1; mfx = 0; mfy = 0;
      vs_prev = 1; upd_pend = 0; p_hit = 0; p_addr = 0;
      exp_rgb = 0; exp_hit = 0; exp_bounce = 0;
    end else begin
      if (p_hit) begin
        idx = int'(mem_m[p_addr]);
        exp_rgb = pal(idx);
        exp_hit = (idx != 0);
      end else begin
        exp_rgb = 0;
        exp_hit = 0;
      end
      if (wr_en) mem_m[wr_addr] = wr_data;
      p_hit = (int'(ix) >= mx) && (int'(ix) < mx + 256) &&
              (int'(iy) >= my) && (int'(iy) < my + 64);
      if (p_hit) begin
        tx = (int'(ix) - mx) / 8;
        ty = (int'(iy) - my) / 8;
        if (mfx) tx = 31 - tx;
        if (mfy) ty = 7 - ty;
        p_addr = ty * 32 + tx;
      end
      exp_bounce = 0;
      if (upd_pend) begin
        move(mx, mdx, mfx, bx, 256, 640);
        move(my, mdy, mfy, by, 64, 480);
        exp_bounce = bx || by;
      end
      upd_pend = !vs_prev && vsync && !freeze;
      vs_prev  = vsync;
    end
    #1;
    chk("model_rgb", int'({red, green, blue}), exp_rgb);
    chk("model_hit", int'(hit), int'(exp_hit));
    chk("model_bounce", int'(bounce), int'(exp_bounce));
    chk("model_x", int'(dut.pos_x_q), mx);
    chk("model_y", int'(dut.pos_y_q), my);
  end

  task automatic probe(input int px, input int py, input int ergb, input int ehit, input string name);
    ix = 16'(px); iy = 16'(py);
    @(negedge clk);
    ix = 0; iy = 0;
    @(negedge clk);
    chk({name, "_rgb"}, int'({red, green, blue}), ergb);
    chk({name, "_hit"}, int'(hit), ehit);
  endtask

  task automatic frame(output bit b_upd, output bit b_after);
    vsync = 0;
    @(negedge clk);
    vsync = 1;
    @(negedge clk);
    @(negedge clk);
    b_upd = bounce;
    @(negedge clk);
    b_after = bounce;
  endtask

  initial begin
    bit b1, b2;
    rst = 1; vsync = 1; freeze = 0; wr_en = 0; wr_addr = 0; wr_data = 0; ix = 0; iy = 0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_x", int'(dut.pos_x_q), 350);
    chk("rst_y", int'(dut.pos_y_q), 16);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("vs_high_no_move", int'(dut.pos_x_q), 350);

    for (int a = 0; a < 256; a++) begin
      wr_en = 1; wr_addr = 8'(a); wr_data = 0;
      @(negedge clk);
    end
    wr_addr = 0; wr_data = 2;
    @(negedge clk);
    wr_en = 0;

    probe(350, 16, 32'hFF0000, 1, "probe_in");
    probe(349, 16, 0, 0, "probe_left");

    frame(b1, b2);
    chk("edge_x", int'(dut.pos_x_q), 351);
    chk("edge_y", int'(dut.pos_y_q), 17);
    chk("edge_no_bounce", int'(b1), 0);

    freeze = 1;
    frame(b1, b2);
    freeze = 0;
    @(negedge clk);
    chk("freeze_x", int'(dut.pos_x_q), 351);
    chk("freeze_y", int'(dut.pos_y_q), 17);

    for (int f = 0; f < 33; f++) frame(b1, b2);
    chk("edge_x_384", int'(dut.pos_x_q), 384);
    chk("edge_y_50", int'(dut.pos_y_q), 50);

    frame(b1, b2);
    chk("bounce_pulse", int'(b1), 1);
    chk("bounce_clear", int'(b2), 0);
    chk("bounce_x", int'(dut.pos_x_q), 384);
    chk("bounce_y", int'(dut.pos_y_q), 51);

    frame(b1, b2);
    chk("back_x", int'(dut.pos_x_q), 383);
    chk("back_y", int'(dut.pos_y_q), 52);

    wr_en = 1; wr_addr = 31; wr_data = 3;
    @(negedge clk);
    wr_en = 0;
    probe(383, 52, 32'hFFFF00, 1, "flip_probe");
    probe(391, 52, 0, 0, "flip_transparent");
    probe(631, 52, 32'hFF0000, 1, "flip_far");

    // texel fx=5 under flip_x is rx=26 -> x=383+208
    ix = 591; iy = 52;
    @(negedge clk);
    ix = 0; iy = 0; wr_en = 1; wr_addr = 5; wr_data = 1;
    @(negedge clk);
    wr_en = 0;
    chk("rdw_old_hit", int'(hit), 0);
    chk("rdw_old_rgb", int'({red, green, blue}), 0);
    probe(591, 52, 32'h202020, 1, "rdw_new");

    ix = 383; iy = 52;
    repeat (3) @(negedge clk);
    chk("line_rgb", int'({red, green, blue}), 32'hFFFF00);
    rst = 1;
    #1;
    chk("rst_async_rgb", int'({red, green, blue}), 0);
    chk("rst_async_hit", int'(hit), 0);
    @(negedge clk);
    ix = 0; iy = 0;
    chk("rst_mid_x", int'(dut.pos_x_q), 350);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_hold", int'(dut.pos_x_q), 350);
    frame(b1, b2);
    chk("post_rst_move_x", int'(dut.pos_x_q), 351);
    chk("post_rst_move_y", int'(dut.pos_y_q), 17);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
